pipeline_hazard_ctrl: RTL

Central stall/flush sequencer for the five-stage MIPS pipeline. It drives the enable, bubble and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers from four sources: cache-miss status, load-use hazards, taken branches and a miss timeout. It replaces the direct wiring of the cache `hit` signal into each pipeline register, so every freeze and squash decision is made in one place.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 23 ++
 rtl/pipeline_hazard_ctrl_if.sv | 40 ++++
 rtl/pipeline_hazard_ctrl_load_use.sv | 13 +
 rtl/pipeline_hazard_ctrl.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// rtl/pipeline_hazard_ctrl_pkg.sv - shared types and defaults for the pipeline hazard controller
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DWAIT = 2'd1,
    ST_IWAIT = 2'd2,
    ST_ERROR = 2'd3
  } state_t;

  // sll $0,$0,0 -- what IF/ID holds after a flush
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam int MISS_TIMEOUT_DEF = 255;
  localparam int CNT_W_DEF        = 16;

  function automatic int wait_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 8) ? 8 : w;
  endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// rtl/pipeline_hazard_ctrl_if.sv - status inputs and pipeline register controls
interface pipeline_hazard_ctrl_if
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
);
  logic             icache_hit;
  logic             dcache_hit;
  logic             mem_access;
  logic             ex_mem_read;
  logic [4:0]       ex_rt;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             branch_taken;
  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             ex_mem_en;
  logic             mem_wb_en;
  logic             id_ex_bubble;
  logic             if_id_flush;
  logic             ex_mem_flush;
  logic             error;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    input  icache_hit, dcache_hit, mem_access, ex_mem_read, ex_rt,
           id_rs, id_rt, id_uses_rt, branch_taken,
    output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           id_ex_bubble, if_id_flush, ex_mem_flush, error, stall_cycles
  );

  modport slave (
    output icache_hit, dcache_hit, mem_access, ex_mem_read, ex_rt,
           id_rs, id_rt, id_uses_rt, branch_taken,
    input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
           id_ex_bubble, if_id_flush, ex_mem_flush, error, stall_cycles
  );
endinterface

// File: rtl/pipeline_hazard_ctrl_load_use.sv
// rtl/pipeline_hazard_ctrl_load_use.sv - combinational load-use hazard comparator
module load_use_detect (
  input  logic       i_ex_mem_read,
  input  logic [4:0] i_ex_rt,
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  input  logic       i_id_uses_rt,
  output logic       o_stall
);
  // $zero is never a real dependency
  assign o_stall = i_ex_mem_read && (i_ex_rt != 5'd0) &&
                   ((i_ex_rt == i_id_rs) || (i_id_uses_rt && (i_ex_rt == i_id_rt)));
endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - central stall/flush sequencer for the five-stage pipeline
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MISS_TIMEOUT = MISS_TIMEOUT_DEF,
  parameter int CNT_W        = CNT_W_DEF
) (
  input logic                   clk,
  input logic                   rst,
  pipeline_hazard_ctrl_if.master hz
);
  localparam int                WAIT_W    = wait_width(MISS_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MISS_TIMEOUT - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_cnt_nxt;
  logic              r_error;
  logic [CNT_W-1:0]  r_stall_cycles;
  logic              w_dmiss;
  logic              w_imiss;
  logic              w_lu_stall;
  logic              w_run_flow;
  logic [4:0]        w_en;
  logic              w_bubble;
  logic              w_if_id_flush;
  logic              w_ex_mem_flush;

  assign w_dmiss = hz.mem_access && !hz.dcache_hit;
  assign w_imiss = !hz.icache_hit;

  load_use_detect u_load_use (
    .i_ex_mem_read (hz.ex_mem_read),
    .i_ex_rt       (hz.ex_rt),
    .i_id_rs       (hz.id_rs),
    .i_id_rt       (hz.id_rt),
    .i_id_uses_rt  (hz.id_uses_rt),
    .o_stall       (w_lu_stall)
  );

  // The wait counter counts frozen miss cycles including the one that detected the miss,
  // so ERROR follows exactly MISS_TIMEOUT miss cycles unless a hit arrives in the last one.
  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_run_flow     = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_wait_cnt_nxt = '0;
        if (w_dmiss) begin
          w_state_nxt    = ST_DWAIT;
          w_wait_cnt_nxt = WAIT_W'(1);
        end else if (w_imiss) begin
          w_state_nxt    = ST_IWAIT;
          w_wait_cnt_nxt = WAIT_W'(1);
        end else begin
          w_run_flow = 1'b1;
        end
      end
      ST_DWAIT: begin
        if (hz.dcache_hit) begin
          w_run_flow     = 1'b1;
          w_state_nxt    = ST_RUN;
          w_wait_cnt_nxt = '0;
        end else if (r_wait_cnt >= WAIT_LAST) begin
          w_state_nxt = ST_ERROR;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
        end
      end
      ST_IWAIT: begin
        if (w_dmiss) begin
          w_state_nxt    = ST_DWAIT;
          w_wait_cnt_nxt = WAIT_W'(1);
        end else if (hz.icache_hit) begin
          w_run_flow     = 1'b1;
          w_state_nxt    = ST_RUN;
          w_wait_cnt_nxt = '0;
        end else if (r_wait_cnt >= WAIT_LAST) begin
          w_state_nxt = ST_ERROR;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + WAIT_W'(1);
        end
      end
      default: begin
      end
    endcase
    if (rst) begin
      w_run_flow     = 1'b0;
      w_state_nxt    = ST_RUN;
      w_wait_cnt_nxt = '0;
    end
  end

  // A taken branch squashes the load-use victim, so it outranks the stall
  always_comb begin
    w_en           = '0;
    w_bubble       = 1'b0;
    w_if_id_flush  = 1'b0;
    w_ex_mem_flush = 1'b0;
    if (w_run_flow) begin
      w_en = '1;
      if (hz.branch_taken) begin
        w_bubble       = 1'b1;
        w_if_id_flush  = 1'b1;
        w_ex_mem_flush = 1'b1;
      end else if (w_lu_stall) begin
        w_en[4:3] = 2'b00;
        w_bubble  = 1'b1;
      end
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      r_state        <= ST_RUN;
      r_wait_cnt     <= '0;
      r_error        <= 1'b0;
      r_stall_cycles <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_state_nxt == ST_ERROR) r_error <= 1'b1;
      if (!w_en[4] && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + CNT_W'(1);
    end
  end

  assign hz.pc_en        = w_en[4];
  assign hz.if_id_en     = w_en[3];
  assign hz.id_ex_en     = w_en[2];
  assign hz.ex_mem_en    = w_en[1];
  assign hz.mem_wb_en    = w_en[0];
  assign hz.id_ex_bubble = w_bubble;
  assign hz.if_id_flush  = w_if_id_flush;
  assign hz.ex_mem_flush = w_ex_mem_flush;
  assign hz.error        = r_error;
  assign hz.stall_cycles = r_stall_cycles;

endmodule
